cv32e40p_rf_wb_arbiter: RTL and testbench
=========================================

Name: cv32e40p_rf_wb_arbiter

Overview:
- Write-back arbiter and scoreboard in front of the two-write-port register file.
- Shares write ports A/B between N_REQ result producers: index 0 = ALU/EX, 1 = LSU, 2 = APU/multicycle.
- Registers the selected writes into the RF write ports.
- Tracks outstanding destination reservations so the ID stage can stall on RAW/WAW hazards.

Parameters:
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32: write data width.
- N_REQ, 3: number of write-back requesters, minimum 2.
- FPU, 0: enables FP registers.
- PULP_ZFINX, 0: FP uses the X registers. NUM_REGS = (FPU && !PULP_ZFINX) ? 64 : 32.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid_i  in  N_REQ  requester has a result
- wb_ready_o  out  N_REQ  result accepted this cycle (combinational)
- wb_addr_i  in  N_REQ*ADDR_WIDTH  destination register, requester r at slice r
- wb_data_i  in  N_REQ*DATA_WIDTH  result data
- we_a_o / waddr_a_o / wdata_a_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF write port A (registered)
- we_b_o / waddr_b_o / wdata_b_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF write port B (registered)
- rsv_valid_i  in  1  ID issues an instruction writing rsv_addr_i
- rsv_addr_i  in  ADDR_WIDTH  destination being reserved
- rsv_ready_o  out  1  reservation can be taken (combinational)
- chk_addr_i  in  3*ADDR_WIDTH  source operand addresses a, b, c
- chk_busy_o  out  3  operand has an outstanding write

Behaviour:
- Reset: we_a_o = we_b_o = 0; waddr_* and wdata_* = 0; round-robin pointer = 1; all pending counters = 0.
- Handshake: a transfer happens when wb_valid_i[r] && wb_ready_o[r]. A requester holds valid, addr and data stable until accepted. wb_ready_o never depends on this cycle's wb_data_i.
- Grant per cycle (at most 2):
  - Requester 0, if valid, takes port A.
  - The remaining free ports go to requesters 1..N_REQ-1 in round-robin order, starting at the pointer.
  - If requester 0 is idle, the first round-robin winner takes A and the second takes B.
- Same-address conflict: two candidates with equal nonzero addresses are never granted together. The higher-priority one (requester 0, then the earlier in round-robin order) is granted; the other waits. Port B then goes to the next eligible candidate, if any.
- Address 0: the request is granted immediately and consumes no port. No RF write and no scoreboard release.
- Output stage: grants are registered. we_x_o, waddr_x_o and wdata_x_o assert in the cycle after acceptance, for exactly 1 cycle. The RF never backpressures, so there is no output stall. Latency from accept to RF sample edge is 1 cycle.
- Round-robin pointer: when at least one requester ≥1 is granted, the pointer moves to one past the last granted requester ≥1, wrapping from N_REQ-1 back to 1. Otherwise it is unchanged.
- Scoreboard:
  - Per register: a 2-bit pending counter for registers 1..NUM_REGS-1; register 0 has none.
  - Reserve: rsv_valid_i && rsv_ready_o increments the counter.
  - Release: each registered we_x_o with nonzero address decrements its counter.
  - Reserve and release of the same register in the same cycle: counter unchanged.
  - Two releases of the same register in one cycle are impossible, by the conflict rule.
  - rsv_ready_o = 0 when the target counter = 3 and no release of it occurs this cycle. It is 1 for address 0, which reserves nothing.
  - chk_busy_o[i] = counter(chk_addr_i[i]) != 0. The value is combinational from the current counters and does not bypass a same-cycle release. Address 0 always reports not busy.
- Release without a prior reservation (counter = 0): counter stays 0 and never underflows. Simulation asserts on this case.
- Reset mid-operation: everything clears immediately, in-flight outputs are dropped, and no RF write is issued.
- Upper address bits beyond NUM_REGS are ignored when FPU = 0.

Decomposition:
- Package cv32e40p_rf_wb_pkg:
  - requester index constants (WB_ALU = 0, WB_LSU = 1, WB_APU = 2);
  - the NUM_REGS function;
  - the pending-counter type (logic [1:0]) and its saturation constant.
- Sub-module cv32e40p_rf_scoreboard: counters, reserve/release, check ports.
- Arbitration and the output registers stay in the top module.

Test Plan:
- After reset, r0 writes x5 = 0x11 and r1 writes x6 = 0x22 in the same cycle. Both are accepted. Next cycle: we_a_o = 1, waddr_a_o = 5, wdata_a_o = 0x11; we_b_o = 1, waddr_b_o = 6, wdata_b_o = 0x22.
- r0, r1 and r2 are all valid to distinct registers for 4 cycles. r0 is accepted every cycle. r1 and r2 alternate on port B in the order r1, r2, r1, r2.
- r0 and r1 both target x7. Only r0 is accepted in cycle 0. r1 is accepted in cycle 1, and its write to x7 appears one cycle later.
- Reserve x9 three times: rsv_ready_o stays 1 through the third. On the fourth attempt rsv_ready_o = 0 and chk_busy_o = 1 for x9. After three writes to x9, chk_busy_o = 0.
- Write to x0 from r1: wb_ready_o[1] = 1 and no we_*_o is asserted. Reserve x0: rsv_ready_o = 1 and chk_busy_o stays 0.
- Assert rst_n low while a write is in the output stage and counters are nonzero. Outputs go to 0 immediately and all chk_busy_o = 0. After reset release, the pointer is 1.

Source files
------------

// File: rtl/cv32e40p_rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter and its
// destination scoreboard.
package cv32e40p_rf_wb_pkg;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_APU = 2;

  typedef logic [1:0] pend_cnt_t;
  localparam pend_cnt_t PEND_MAX = 2'd3;

  // FP registers get their own bank only when they are not aliased onto X.
  function automatic int num_regs(input int fpu, input int pulp_zfinx);
    return ((fpu != 0) && (pulp_zfinx == 0)) ? 64 : 32;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter_if.sv
// Result bus from the write-back producers (ALU, LSU, APU) to the arbiter.
interface cv32e40p_rf_wb_arbiter_if #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            wb_valid;
  logic [N_REQ-1:0]            wb_ready;
  logic [N_REQ*ADDR_WIDTH-1:0] wb_addr;
  logic [N_REQ*DATA_WIDTH-1:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/cv32e40p_rf_scoreboard.sv
// Per-register pending-write counters: ID reserves destinations, registered
// RF writes release them, and source operands are checked for hazards.
module cv32e40p_rf_scoreboard
  import cv32e40p_rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rel_a_i,
  input  logic [ADDR_WIDTH-1:0]   rel_a_addr_i,
  input  logic                    rel_b_i,
  input  logic [ADDR_WIDTH-1:0]   rel_b_addr_i,
  input  logic                    rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]   rsv_addr_i,
  output logic                    rsv_ready_o,
  input  logic [3*ADDR_WIDTH-1:0] chk_addr_i,
  output logic [2:0]              chk_busy_o
);
  localparam int IW = $clog2(NUM_REGS);

  pend_cnt_t             cnt_q [NUM_REGS];
  pend_cnt_t             cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic [IW-1:0]         rsv_idx, rel_a_idx, rel_b_idx;
  logic                  rsv_fire;

  // Bits above the register index only carry meaning when an FP bank exists.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rsv_addr_i, chk_addr_i, rel_a_addr_i, rel_b_addr_i};

  always_comb begin
    rsv_idx   = rsv_addr_i[IW-1:0];
    rel_a_idx = rel_a_addr_i[IW-1:0];
    rel_b_idx = rel_b_addr_i[IW-1:0];
    rsv_ready_o = (rsv_idx == '0) || (cnt_q[rsv_idx] != PEND_MAX) ||
                  (rel_a_i && (rel_a_idx == rsv_idx)) ||
                  (rel_b_i && (rel_b_idx == rsv_idx));
    rsv_fire = rsv_valid_i && rsv_ready_o && (rsv_idx != '0);
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = rsv_fire && (rsv_idx == IW'(r));
      dec_vec[r] = (rel_a_i && (rel_a_idx == IW'(r))) ||
                   (rel_b_i && (rel_b_idx == IW'(r)));
      cnt_d[r]   = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + pend_cnt_t'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - pend_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    assign chk_busy_o[gi] = (cnt_q[chk_addr_i[gi*ADDR_WIDTH +: IW]] != '0);
  end

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_no_underflow
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(dec_vec[gi] && !inc_vec[gi] && (cnt_q[gi] == '0)));
  end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Shares the two RF write ports among the write-back producers, registers the
// granted writes and feeds the releases into the destination scoreboard.
module cv32e40p_rf_wb_arbiter
  import cv32e40p_rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 3,
  parameter int FPU        = 0,
  parameter int PULP_ZFINX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cv32e40p_rf_wb_arbiter_if.slave wb,
  output logic                    we_a_o,
  output logic [ADDR_WIDTH-1:0]   waddr_a_o,
  output logic [DATA_WIDTH-1:0]   wdata_a_o,
  output logic                    we_b_o,
  output logic [ADDR_WIDTH-1:0]   waddr_b_o,
  output logic [DATA_WIDTH-1:0]   wdata_b_o,
  input  logic                    rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]   rsv_addr_i,
  output logic                    rsv_ready_o,
  input  logic [3*ADDR_WIDTH-1:0] chk_addr_i,
  output logic [2:0]              chk_busy_o
);
  localparam int NUM_REGS = num_regs(FPU, PULP_ZFINX);
  localparam int IW       = $clog2(NUM_REGS);
  localparam int PW       = $clog2(N_REQ);

  logic [ADDR_WIDTH-1:0] req_addr [N_REQ];
  logic [DATA_WIDTH-1:0] req_data [N_REQ];
  logic [IW-1:0]         req_idx  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_addr[gi] = wb.wb_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data[gi] = wb.wb_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_idx[gi]  = req_addr[gi][IW-1:0];
  end

  logic [N_REQ-1:0]      ready;
  logic [PW-1:0]         ptr_q, ptr_d, rr, sel_a, sel_b;
  logic                  gnt_a, gnt_b;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

  // ALU owns port A when it has a result; the others rotate over what is left.
  // x0 results are acked without a port; a candidate matching port A's
  // register is skipped so both ports never write the same register.
  always_comb begin
    ready = '0;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    rr    = '0;
    ptr_d = ptr_q;
    if (wb.wb_valid[WB_ALU]) begin
      ready[WB_ALU] = 1'b1;
      gnt_a         = (req_idx[WB_ALU] != '0);
      sel_a         = PW'(WB_ALU);
    end
    for (int k = 0; k < N_REQ - 1; k++) begin
      rr = PW'(((int'(ptr_q) - 1 + k) % (N_REQ - 1)) + 1);
      if (wb.wb_valid[rr]) begin
        if (req_idx[rr] == '0) begin
          ready[rr] = 1'b1;
        end else if (!gnt_a) begin
          ready[rr] = 1'b1;
          gnt_a     = 1'b1;
          sel_a     = rr;
        end else if (!gnt_b && (req_idx[rr] != req_idx[sel_a])) begin
          ready[rr] = 1'b1;
          gnt_b     = 1'b1;
          sel_b     = rr;
        end
        if (ready[rr]) ptr_d = (int'(rr) == N_REQ - 1) ? PW'(1) : rr + PW'(1);
      end
    end
    we_a_d    = gnt_a;
    waddr_a_d = gnt_a ? req_addr[sel_a] : '0;
    wdata_a_d = gnt_a ? req_data[sel_a] : '0;
    we_b_d    = gnt_b;
    waddr_b_d = gnt_b ? req_addr[sel_b] : '0;
    wdata_b_d = gnt_b ? req_data[sel_b] : '0;
  end

  assign wb.wb_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PW'(1);
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;

  cv32e40p_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .rel_a_i      (we_a_q),
    .rel_a_addr_i (waddr_a_q),
    .rel_b_i      (we_b_q),
    .rel_b_addr_i (waddr_b_q),
    .rsv_valid_i  (rsv_valid_i),
    .rsv_addr_i   (rsv_addr_i),
    .rsv_ready_o  (rsv_ready_o),
    .chk_addr_i   (chk_addr_i),
    .chk_busy_o   (chk_busy_o)
  );

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed bench: stimulus queues the expected RF writes, a negedge monitor
// pops and compares them as they appear on ports A/B.
module tb_cv32e40p_rf_wb_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  logic          rsv_valid_i;
  logic [AW-1:0] rsv_addr_i;
  logic          rsv_ready_o;
  logic [3*AW-1:0] chk_addr_i;
  logic [2:0]    chk_busy_o;

  cv32e40p_rf_wb_arbiter_if #(.N_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

  cv32e40p_rf_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(3), .FPU(0), .PULP_ZFINX(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb_if),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i), .rsv_ready_o(rsv_ready_o),
    .chk_addr_i(chk_addr_i), .chk_busy_o(chk_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.port = port;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_wr(input bit port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: got port %0d x%0d=0x%0h, required no write", port, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("wr_port", 64'(port), 64'(e.port));
      check("wr_addr", 64'(addr), 64'(e.addr));
      check("wr_data", 64'(data), 64'(e.data));
      $display("rf write port %s x%0d = 0x%0h", port ? "B" : "A", addr, data);
    end
  endtask

  always @(negedge clk) begin
    if (we_a_o) check_wr(1'b0, waddr_a_o, wdata_a_o);
    if (we_b_o) check_wr(1'b1, waddr_b_o, wdata_b_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wb_if.wb_valid = '0;
    wb_if.wb_addr  = '0;
    wb_if.wb_data  = '0;
    rsv_valid_i    = 1'b0;
    rsv_addr_i     = '0;
    chk_addr_i     = '0;
  endtask

  task automatic wb(input string name, input logic [2:0] v,
                    input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                    input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                    input logic [2:0] exp_rdy);
    step();
    clear_in();
    wb_if.wb_valid = v;
    wb_if.wb_addr  = {a2, a1, a0};
    wb_if.wb_data  = {d2, d1, d0};
    #2 check(name, 64'(wb_if.wb_ready), 64'(exp_rdy));
  endtask

  task automatic reserve(input logic [AW-1:0] a, input logic exp_rdy);
    step();
    clear_in();
    rsv_valid_i = 1'b1;
    rsv_addr_i  = a;
    #2 check("rsv_ready", 64'(rsv_ready_o), 64'(exp_rdy));
  endtask

  initial begin
    clear_in();
    @(posedge clk);
    #1;
    check("rst_we_a", 64'(we_a_o), 64'd0);
    check("rst_we_b", 64'(we_b_o), 64'd0);
    check("rst_waddr_a", 64'(waddr_a_o), 64'd0);
    check("rst_wdata_b", 64'(wdata_b_o), 64'd0);
    check("rst_busy", 64'(chk_busy_o), 64'd0);
    rst_n = 1'b1;

    // ALU and LSU in the same cycle land on A and B
    reserve(6'd5, 1'b1);
    reserve(6'd6, 1'b1);
    wb("t1_ready", 3'b011, 6'd5, 32'h11, 6'd6, 32'h22, 6'd0, 32'h0, 3'b011);
    push(1'b0, 6'd5, 32'h11);
    push(1'b1, 6'd6, 32'h22);

    // APU alone brings the pointer back to LSU
    reserve(6'd8, 1'b1);
    wb("t1b_ready", 3'b100, 6'd0, 32'h0, 6'd0, 32'h0, 6'd8, 32'h88, 3'b100);
    push(1'b0, 6'd8, 32'h88);

    // three requesters for four cycles: LSU and APU alternate on B
    for (int i = 10; i <= 17; i++) reserve(AW'(i), 1'b1);
    wb("t2_c0", 3'b111, 6'd10, 32'h110, 6'd14, 32'h214, 6'd16, 32'h316, 3'b011);
    push(1'b0, 6'd10, 32'h110);
    push(1'b1, 6'd14, 32'h214);
    wb("t2_c1", 3'b111, 6'd11, 32'h111, 6'd15, 32'h215, 6'd16, 32'h316, 3'b101);
    push(1'b0, 6'd11, 32'h111);
    push(1'b1, 6'd16, 32'h316);
    wb("t2_c2", 3'b111, 6'd12, 32'h112, 6'd15, 32'h215, 6'd17, 32'h317, 3'b011);
    push(1'b0, 6'd12, 32'h112);
    push(1'b1, 6'd15, 32'h215);
    wb("t2_c3", 3'b111, 6'd13, 32'h113, 6'd18, 32'h218, 6'd17, 32'h317, 3'b101);
    push(1'b0, 6'd13, 32'h113);
    push(1'b1, 6'd17, 32'h317);

    // same-register conflict: LSU waits, APU takes B
    reserve(6'd7, 1'b1);
    reserve(6'd7, 1'b1);
    reserve(6'd19, 1'b1);
    wb("t3_c0", 3'b111, 6'd7, 32'h70, 6'd7, 32'h71, 6'd19, 32'h319, 3'b101);
    push(1'b0, 6'd7, 32'h70);
    push(1'b1, 6'd19, 32'h319);
    wb("t3_c1", 3'b010, 6'd0, 32'h0, 6'd7, 32'h71, 6'd0, 32'h0, 3'b010);
    push(1'b0, 6'd7, 32'h71);

    // pending counter saturation on x9
    reserve(6'd9, 1'b1);
    reserve(6'd9, 1'b1);
    reserve(6'd9, 1'b1);
    reserve(6'd9, 1'b0);
    chk_addr_i = {6'd0, 6'd0, 6'd9};
    #1 check("t4_busy_full", 64'(chk_busy_o), 64'b001);
    wb("t4_w0", 3'b010, 6'd0, 32'h0, 6'd9, 32'h91, 6'd0, 32'h0, 3'b010);
    push(1'b0, 6'd9, 32'h91);
    rsv_addr_i = 6'd9;
    #1 check("t4_rsv_no_release", 64'(rsv_ready_o), 64'd0);
    wb("t4_w1", 3'b010, 6'd0, 32'h0, 6'd9, 32'h92, 6'd0, 32'h0, 3'b010);
    push(1'b0, 6'd9, 32'h92);
    rsv_addr_i = 6'd9;
    #1 check("t4_rsv_with_release", 64'(rsv_ready_o), 64'd1);
    wb("t4_w2", 3'b010, 6'd0, 32'h0, 6'd9, 32'h93, 6'd0, 32'h0, 3'b010);
    push(1'b0, 6'd9, 32'h93);
    step();
    clear_in();
    chk_addr_i = {6'd0, 6'd0, 6'd9};
    #1 check("t4_busy_one_left", 64'(chk_busy_o), 64'b001);
    step();
    chk_addr_i = {6'd0, 6'd0, 6'd9};
    #1 check("t4_busy_clear", 64'(chk_busy_o), 64'b000);

    // x0 consumes no port and reserves nothing
    wb("t5_x0_ready", 3'b010, 6'd0, 32'h0, 6'd0, 32'hdead, 6'd0, 32'h0, 3'b010);
    step();
    clear_in();
    check("t5_no_we_a", 64'(we_a_o), 64'd0);
    check("t5_no_we_b", 64'(we_b_o), 64'd0);
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 6'd0;
    chk_addr_i  = {6'd0, 6'd0, 6'd0};
    #2 check("t5_rsv_x0", 64'(rsv_ready_o), 64'd1);
    step();
    clear_in();
    #1 check("t5_busy_x0", 64'(chk_busy_o), 64'b000);

    // reset while a write sits in the output stage
    reserve(6'd20, 1'b1);
    reserve(6'd21, 1'b1);
    reserve(6'd22, 1'b1);
    wb("t6_lsu", 3'b010, 6'd0, 32'h0, 6'd20, 32'h2020, 6'd0, 32'h0, 3'b010);
    push(1'b0, 6'd20, 32'h2020);
    wb("t6_alu", 3'b001, 6'd21, 32'h2121, 6'd0, 32'h0, 6'd0, 32'h0, 3'b001);
    step();
    clear_in();
    chk_addr_i = {6'd7, 6'd22, 6'd21};
    #1;
    check("t6_inflight_we", 64'(we_a_o), 64'd1);
    check("t6_inflight_addr", 64'(waddr_a_o), 64'd21);
    check("t6_busy_before", 64'(chk_busy_o), 64'b011);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we_a", 64'(we_a_o), 64'd0);
    check("t6_rst_waddr_a", 64'(waddr_a_o), 64'd0);
    check("t6_rst_wdata_a", 64'(wdata_a_o), 64'd0);
    check("t6_rst_busy", 64'(chk_busy_o), 64'b000);
    step();
    step();
    rst_n = 1'b1;
    reserve(6'd23, 1'b1);
    reserve(6'd24, 1'b1);
    wb("t6_ptr_after_rst", 3'b111, 6'd23, 32'h2323, 6'd24, 32'h2424, 6'd25, 32'h2525, 3'b011);
    push(1'b0, 6'd23, 32'h2323);
    push(1'b1, 6'd24, 32'h2424);

    step();
    clear_in();
    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
